// File: rtl/axi_slave.sv
// Receive side of the 32-bit valid/ready message link. Words land in a circular FIFO and are handed to the core through an enable/done port.
// Optional macro AXI_SLAVE_STATS_EN builds the 16-bit accepted-word counter on rx_cnt_o; when it is undefined, rx_cnt_o is tied to zero.
module axi_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] message_i,
  output logic              ready_o,
  input  logic              enable_i,
  output logic [DATA_W-1:0] message_o,
  output logic              done_o,
  output logic [ADDR_W:0]   level_o,
  output logic [15:0]       rx_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              w_push;
  logic              w_pop;
  logic              w_not_empty;

  // Both handshakes are decoded from the registered level only, so neither valid_i nor enable_i feeds ready_o.
  assign w_not_empty = (r_level != '0);
  assign ready_o     = (r_level != LVL_FULL);
  assign done_o      = enable_i && w_not_empty;
  assign w_push      = valid_i && ready_o;
  assign w_pop       = done_o;
  assign message_o   = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign level_o     = r_level;

  // Storage is deliberately left out of reset; the pointers and level alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= message_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef AXI_SLAVE_STATS_EN
  logic [15:0] r_rx_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rx_cnt <= '0;
    end else if (w_push) begin
      r_rx_cnt <= r_rx_cnt + 16'd1;
    end
  end

  assign rx_cnt_o = r_rx_cnt;
`else
  assign rx_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axi_slave.sv
// Randomized and directed bench for axi_slave, checked against a queue-based FIFO model.
module tb_axi_slave;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] message_i = '0;
  logic        ready_o;
  logic        enable_i = 1'b0;
  logic [31:0] message_o;
  logic        done_o;
  logic [2:0]  level_o;
  logic [15:0] rx_cnt_o;

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] model_q [$];
  logic [15:0] model_cnt = '0;

  axi_slave dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .valid_i   (valid_i),
    .message_i (message_i),
    .ready_o   (ready_o),
    .enable_i  (enable_i),
    .message_o (message_o),
    .done_o    (done_o),
    .level_o   (level_o),
    .rx_cnt_o  (rx_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Counter expectation: incremented per accepted word when the stats build is enabled, otherwise always zero.
  function automatic logic [15:0] exp_cnt();
`ifdef AXI_SLAVE_STATS_EN
    return model_cnt;
`else
    return 16'h0000;
`endif
  endfunction

  // One clock cycle: drive inputs after the falling edge, check outputs, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [31:0] m, input logic e);
    logic        exp_ready;
    logic        exp_done;
    logic [31:0] exp_msg;
    int          lvl;
    @(negedge clk_i);
    valid_i   = v;
    message_i = m;
    enable_i  = e;
    #1;
    lvl       = model_q.size();
    exp_ready = (lvl != DEPTH);
    exp_done  = e && (lvl != 0);
    exp_msg   = (lvl != 0) ? model_q[0] : 32'h0;
    chk_eq("level", 32'(level_o), 32'(lvl));
    chk_eq("ready", 32'(ready_o), 32'(exp_ready));
    chk_eq("done", 32'(done_o), 32'(exp_done));
    chk_eq("message", message_o, exp_msg);
    chk_eq("rx_cnt", 32'(rx_cnt_o), 32'(exp_cnt()));
    $display("step v=%0b m=%h e=%0b lvl=%0d push=%0b pop=%0b out=%h",
             v, m, e, lvl, v && exp_ready, exp_done, exp_msg);
    @(posedge clk_i);
    if (exp_done) void'(model_q.pop_front());
    if (v && exp_ready) begin
      model_q.push_back(m);
      model_cnt = model_cnt + 16'd1;
    end
  endtask

  // Reset asserted between edges; its effect must show before the next rising edge.
  task automatic do_reset();
    @(negedge clk_i);
    #2;
    valid_i  = 1'b0;
    enable_i = 1'b1;
    reset_i  = 1'b1;
    #1;
    chk_eq("rst_ready", 32'(ready_o), 32'd1);
    chk_eq("rst_level", 32'(level_o), 32'd0);
    chk_eq("rst_done", 32'(done_o), 32'd0);
    chk_eq("rst_message", message_o, 32'h0);
    chk_eq("rst_rx_cnt", 32'(rx_cnt_o), 32'h0);
    $display("reset asserted asynchronously");
    model_q.delete();
    model_cnt = '0;
    @(negedge clk_i);
    reset_i  = 1'b0;
    enable_i = 1'b0;
  endtask

  initial begin
    #1;
    chk_eq("init_ready", 32'(ready_o), 32'd1);
    chk_eq("init_level", 32'(level_o), 32'd0);
    chk_eq("init_done", 32'(done_o), 32'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    // Reset in the middle of a stream, then a single push/pop.
    step(1'b1, 32'h1111_0000, 1'b0);
    step(1'b1, 32'h1111_0001, 1'b0);
    do_reset();
    step(1'b1, 32'hA5A5_0001, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Fill to full, an ignored fifth word, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(i), 1'b0);
    step(1'b1, 32'h14, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Core stalls on an empty FIFO, then consumes a word one cycle after it lands.
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h55, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Hold level at 2 with simultaneous push and pop; pointers wrap several times.
    step(1'b1, 32'h1E, 1'b0);
    step(1'b1, 32'h1F, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h20 + 32'(i), 1'b1);

    // Full FIFO: ready stays low even when the core pops in the same cycle.
    step(1'b1, 32'h30, 1'b0);
    step(1'b1, 32'h31, 1'b0);
    step(1'b1, 32'h32, 1'b1);
    step(1'b1, 32'h33, 1'b0);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
      end
    end
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
